// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor counter encodings and PC index/tag slicing helpers.
package bp_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    localparam logic [1:0] CNT_INIT_TAKEN = CNT_WT;
    localparam logic [1:0] CNT_INIT_NT    = CNT_WNT;

    function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: stage-1 lookup, stage-4 update and statistics signals of the BTB.
interface branch_target_buffer_if;
    logic [31:0] pc_s1;
    logic        hit_s1;
    logic        p_s1;
    logic [31:0] target_s1;
    logic [31:0] pc_s4;
    logic [31:0] target_s4;
    logic        deviated_s4;
    logic        write_rt;
    logic        write_rp;
    logic [31:0] n_alloc;
    logic [31:0] n_evict;

    modport master (
        output pc_s1, pc_s4, target_s4, deviated_s4, write_rt, write_rp,
        input  hit_s1, p_s1, target_s1, n_alloc, n_evict
    );

    modport slave (
        input  pc_s1, pc_s4, target_s4, deviated_s4, write_rt, write_rp,
        output hit_s1, p_s1, target_s1, n_alloc, n_evict
    );
endinterface

// File: rtl/sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       up,
    output logic [1:0] nxt
);
    always_comb nxt = up ? ((cur == CNT_ST) ? cur : cur + 2'd1)
                         : ((cur == CNT_SNT) ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters, combinational lookup
// and stage-4 allocate/retrain writes.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
)(
    input logic                   clk,
    input logic                   rst_n,
    branch_target_buffer_if.slave bus
);
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         cnt_q [ENTRIES];
    logic [31:0]        alloc_q, evict_q;
    logic [IDX_W-1:0]   ri, wi;
    logic [TAG_W-1:0]   rt, wt;
    logic               hit, w_hit;
    logic [1:0]         cnt_nxt;

    assign ri  = IDX_W'(bp_idx(bus.pc_s1, IDX_W));
    assign rt  = TAG_W'(bp_tag(bus.pc_s1, IDX_W));
    assign wi  = IDX_W'(bp_idx(bus.pc_s4, IDX_W));
    assign wt  = TAG_W'(bp_tag(bus.pc_s4, IDX_W));
    assign hit   = valid[ri] && (tag_q[ri] == rt);
    assign w_hit = valid[wi] && (tag_q[wi] == wt);

    assign bus.hit_s1    = hit;
    assign bus.p_s1      = hit & cnt_q[ri][1];
    assign bus.target_s1 = hit ? tgt_q[ri] : 32'd0;
    assign bus.n_alloc   = alloc_q;
    assign bus.n_evict   = evict_q;

    sat_counter2 u_sat (
        .cur (cnt_q[wi]),
        .up  (bus.deviated_s4),
        .nxt (cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            alloc_q <= '0;
            evict_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_INIT_NT;
            end
        end else if (bus.write_rt) begin
            valid[wi] <= 1'b1;
            tag_q[wi] <= wt;
            tgt_q[wi] <= bus.target_s4;
            cnt_q[wi] <= bus.deviated_s4 ? CNT_INIT_TAKEN : CNT_INIT_NT;
            alloc_q   <= alloc_q + 32'd1;
            if (valid[wi] && !w_hit)
                evict_q <= evict_q + 32'd1;
        end else if (bus.write_rp && w_hit) begin
            // a miss here means the line was replaced while the branch was in flight
            cnt_q[wi] <= cnt_nxt;
            if (bus.deviated_s4)
                tgt_q[wi] <= bus.target_s4;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed vectors with hand-computed expectations for the BTB.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    branch_target_buffer_if bus ();

    branch_target_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_write(input logic rt, input logic rp, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic dev);
        bus.write_rt    = rt;
        bus.write_rp    = rp;
        bus.pc_s4       = pc;
        bus.target_s4   = tgt;
        bus.deviated_s4 = dev;
        @(posedge clk);
        #1;
        bus.write_rt = 1'b0;
        bus.write_rp = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h,
                        input logic p, input logic [31:0] tgt);
        bus.pc_s1 = pc;
        #1;
        check({tag, ".hit"}, 32'(bus.hit_s1), 32'(h));
        check({tag, ".p"}, 32'(bus.p_s1), 32'(p));
        check({tag, ".tgt"}, bus.target_s1, tgt);
    endtask

    initial begin
        bus.pc_s1 = '0; bus.pc_s4 = '0; bus.target_s4 = '0;
        bus.deviated_s4 = 1'b0; bus.write_rt = 1'b0; bus.write_rp = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        look("rst", 32'h40, 0, 0, 32'h0);
        check("rst.n_alloc", bus.n_alloc, 32'd0);
        check("rst.n_evict", bus.n_evict, 32'd0);

        do_write(1, 0, 32'h40, 32'h100, 1);
        look("alloc40", 32'h40, 1, 1, 32'h100);
        check("alloc40.n_alloc", bus.n_alloc, 32'd1);
        check("alloc40.n_evict", bus.n_evict, 32'd0);

        // 10 -> 11 -> 11 (taken retrains also rewrite target)
        do_write(0, 1, 32'h40, 32'h104, 1);
        look("inc1", 32'h40, 1, 1, 32'h104);
        do_write(0, 1, 32'h40, 32'h104, 1);
        look("inc2", 32'h40, 1, 1, 32'h104);
        // 11 -> 10 -> 01 -> 00 -> 00, target untouched on not-taken
        do_write(0, 1, 32'h40, 32'h999, 0);
        look("dec1", 32'h40, 1, 1, 32'h104);
        do_write(0, 1, 32'h40, 32'h999, 0);
        look("dec2", 32'h40, 1, 0, 32'h104);
        do_write(0, 1, 32'h40, 32'h999, 0);
        look("dec3", 32'h40, 1, 0, 32'h104);
        do_write(0, 1, 32'h40, 32'h999, 0);
        look("dec4", 32'h40, 1, 0, 32'h104);
        do_write(0, 1, 32'h40, 32'h104, 1);
        look("inc_from0", 32'h40, 1, 0, 32'h104);
        do_write(0, 1, 32'h40, 32'h104, 1);
        look("inc_to2", 32'h40, 1, 1, 32'h104);

        do_write(1, 0, 32'h440, 32'h200, 0);
        check("conf.n_alloc", bus.n_alloc, 32'd2);
        check("conf.n_evict", bus.n_evict, 32'd1);
        look("conf.old", 32'h40, 0, 0, 32'h0);
        look("conf.new", 32'h440, 1, 0, 32'h200);
        do_write(0, 1, 32'h40, 32'h300, 1);
        look("stale_rp", 32'h440, 1, 0, 32'h200);
        do_write(1, 1, 32'h440, 32'h204, 1);
        check("realloc.n_alloc", bus.n_alloc, 32'd3);
        check("realloc.n_evict", bus.n_evict, 32'd1);
        look("realloc", 32'h440, 1, 1, 32'h204);

        bus.pc_s1 = 32'h80;
        bus.write_rt = 1'b1; bus.write_rp = 1'b0;
        bus.pc_s4 = 32'h80; bus.target_s4 = 32'h180; bus.deviated_s4 = 1'b0;
        #1;
        check("bypass.before", 32'(bus.hit_s1), 32'd0);
        @(posedge clk);
        #1;
        bus.write_rt = 1'b0;
        #1;
        look("bypass.after", 32'h80, 1, 0, 32'h180);
        look("lowbits", 32'h83, 1, 0, 32'h180);
        check("same.n_evict", bus.n_evict, 32'd2);
        do_write(1, 0, 32'h44, 32'h144, 1);
        look("idx1", 32'h44, 1, 1, 32'h144);
        look("idx0_kept", 32'h80, 1, 0, 32'h180);
        check("idx1.n_alloc", bus.n_alloc, 32'd5);

        #2 rst_n = 1'b0;
        look("arst.idx1", 32'h44, 0, 0, 32'h0);
        check("arst.n_alloc", bus.n_alloc, 32'd0);
        check("arst.n_evict", bus.n_evict, 32'd0);
        do_write(1, 0, 32'h80, 32'h180, 1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        look("post.idx0", 32'h80, 0, 0, 32'h0);
        look("post.idx1", 32'h44, 0, 0, 32'h0);
        check("post.n_alloc", bus.n_alloc, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
